// File: rtl/reg_fifo_pkg.sv
// Shared defaults and width helpers for the register-based FWFT FIFO.
package reg_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Pointer width: DEPTH is a power of two, so pointers wrap on their own.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must also represent the full value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register.sv
// Common storage register: loads d_i when clk_en_i is high, no reset on the data path.
`ifndef REGISTER_SV
`define REGISTER_SV

module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clk_en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (clk_en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

`endif

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides; storage is one
// `register` per entry, control (pointers, occupancy) is local and async-reset.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  // Handshake: a beat transfers on a side exactly when valid && ready at posedge clk.
  // in_ready is a function of count only, so a full FIFO refuses a push even while
  // it is popping; out_* are functions of registered state only.

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_q];
  assign count     = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    register #(.WIDTH(WIDTH)) u_entry (
      .clk_i    (clk),
      .clk_en_i (push && (wr_ptr_q == PTR_W'(i))),
      .d_i      (in_data),
      .q_o      (mem[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == '0)));
`endif

endmodule

// File: tb/tb_reg_fifo.sv
// Directed scenarios plus a random valid/ready soak for reg_fifo, checked against
// a queue-based model of FIFO occupancy and ordering.
module tb_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;

  logic [WIDTH-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Checks outputs against the model before the edge, advances one clock,
  // then applies the FIFO rules to the model and checks the new occupancy.
  task automatic cycle();
    bit               do_push, do_pop;
    logic [WIDTH-1:0] d;
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) check("head", {24'd0, out_data}, {24'd0, exp_q[0]});
    d = in_data;
    @(posedge clk);
    #1;
    if (flush) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    check("count", {29'd0, count}, exp_q.size());
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    tests_run    = 0;
    tests_failed = 0;
    fill_vals    = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // 1: reset state before any clock edge, then idle after release
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {29'd0, count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) cycle();
    check("idle_count", {29'd0, count}, 32'd0);

    // 2: fill, reject fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_vals[i], 1'b0, 1'b0);
      cycle();
    end
    check("full_count", {29'd0, count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    cycle();
    check("reject_count", {29'd0, count}, 32'd4);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", {24'd0, out_data}, {24'd0, fill_vals[i]});
      cycle();
    end
    check("drained_valid", {31'd0, out_valid}, 32'd0);

    // 3: steady push&pop at count 2 across several pointer wraps
    drive(1'b1, 8'h01, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h02, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1, 1'b0);
      cycle();
      check("steady_count", {29'd0, count}, 32'd2);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle();

    // 4: full with simultaneous pop: pop wins, push refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    cycle();
    check("fullpop_count", {29'd0, count}, 32'd3);
    check("fullpop_in_ready", {31'd0, in_ready}, 32'd1);

    // 5: flush overrides push and pop in the same cycle
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    cycle();
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle();
    check("post_flush_head", {24'd0, out_data}, 32'h0000_00A5);
    check("post_flush_valid", {31'd0, out_valid}, 32'd1);

    // 6: async reset between edges clears state immediately
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle();
    check("pre_rst_count", {29'd0, count}, 32'd2);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_count", {29'd0, count}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // Random soak with occasional flush
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 255) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
